true_dpr_param: RTL and testbench

//  Parametrised true dual-port RAM, the successor to the fixed 8x4096 true_dpr.
//  Two independent read/write ports share one clock. Both ports add byte-lane write enables,
//  a selectable read-during-write mode, an optional output pipeline stage and read-valid flags.

---
 rtl/true_dpr_param.sv | 199 +++++++++++++++++++
 tb/tb_true_dpr_param.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/true_dpr_param.sv
// true_dpr_param: parametrised true dual-port RAM with byte-lane writes,
// selectable read-during-write response, optional output register,
// same-address collision reporting and a post-reset array clear.

module true_dpr_param #(
  parameter int DATA_W     = 8,
  parameter int LANE_W     = 8,
  parameter int ADDR_W     = 12,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     init_busy,
  input  logic                     en_0,
  input  logic                     wr_en_0,
  input  logic [DATA_W/LANE_W-1:0] be_0,
  input  logic [ADDR_W-1:0]        addr_0,
  input  logic [DATA_W-1:0]        in_0,
  output logic [DATA_W-1:0]        out_0,
  output logic                     valid_0,
  input  logic                     en_1,
  input  logic                     wr_en_1,
  input  logic [DATA_W/LANE_W-1:0] be_1,
  input  logic [ADDR_W-1:0]        addr_1,
  input  logic [DATA_W-1:0]        in_1,
  output logic [DATA_W-1:0]        out_1,
  output logic                     valid_1,
  output logic                     coll_err
);

  localparam int NL    = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  localparam state_e RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clrCnt_q, clrCnt_d;

  logic              run;
  logic              acc0, acc1, wr0, wr1, sameAddr, coll;
  logic [DATA_W-1:0] old0, old1, final0, final1;
  logic [DATA_W-1:0] respData0, respData1;
  logic              respValid0, respValid1;

  logic [DATA_W-1:0] s1Data0_q, s1Data1_q;
  logic              s1Valid0_q, s1Valid1_q, s1Coll_q;

  // Overlay the enabled lanes of data onto base.
  function automatic logic [DATA_W-1:0] mergeLanes(input logic [DATA_W-1:0] base,
                                                   input logic [DATA_W-1:0] data,
                                                   input logic [NL-1:0]     be);
    logic [DATA_W-1:0] res;
    res = base;
    for (int i = 0; i < NL; i++) begin
      if (be[i]) res[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
    end
    return res;
  endfunction

  // Clear sequencer: walk every address once, then hand over to normal access.
  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    if (state_q == ST_CLEAR) begin
      clrCnt_d = clrCnt_q + 1'b1;
      if (&clrCnt_q) state_d = ST_RUN;
    end
  end

  // State and clear-counter registers; reset always restarts the clear at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESET_STATE;
      clrCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
    end
  end

  assign init_busy = (state_q == ST_CLEAR);
  assign run       = (state_q == ST_RUN);

  // Request qualification and collision detection (requests dropped while clearing).
  always_comb begin
    acc0     = run & en_0;
    acc1     = run & en_1;
    wr0      = acc0 & wr_en_0;
    wr1      = acc1 & wr_en_1;
    sameAddr = (addr_0 == addr_1);
    coll     = acc0 & acc1 & sameAddr & (wr_en_0 | wr_en_1);
  end

  // Old words and the word each address will hold after this edge; port 0 lanes win.
  always_comb begin
    old0   = mem[addr_0];
    old1   = mem[addr_1];
    final0 = old0;
    if (wr1 && sameAddr) final0 = mergeLanes(final0, in_1, be_1);
    if (wr0)             final0 = mergeLanes(final0, in_0, be_0);
    final1 = old1;
    if (wr1)             final1 = mergeLanes(final1, in_1, be_1);
    if (wr0 && sameAddr) final1 = mergeLanes(final1, in_0, be_0);
  end

  // Per-port response: readers always see the old word, writers follow RD_MODE.
  always_comb begin
    respValid0 = 1'b0;
    respData0  = old0;
    respValid1 = 1'b0;
    respData1  = old1;
    if (acc0) begin
      if (!wr_en_0 || RD_MODE == 0) begin
        respValid0 = 1'b1;
      end else if (RD_MODE == 1) begin
        respValid0 = 1'b1;
        respData0  = final0;
      end
    end
    if (acc1) begin
      if (!wr_en_1 || RD_MODE == 0) begin
        respValid1 = 1'b1;
      end else if (RD_MODE == 1) begin
        respValid1 = 1'b1;
        respData1  = final1;
      end
    end
  end

  // Array update: clear writes zero, otherwise lane writes with port 0 applied last.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clrCnt_q] <= '0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (wr1 && be_1[i]) mem[addr_1][i*LANE_W +: LANE_W] <= in_1[i*LANE_W +: LANE_W];
        if (wr0 && be_0[i]) mem[addr_0][i*LANE_W +: LANE_W] <= in_0[i*LANE_W +: LANE_W];
      end
    end
  end

  // First output stage: data only moves on a valid response so it holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Data0_q  <= '0;
      s1Data1_q  <= '0;
      s1Valid0_q <= 1'b0;
      s1Valid1_q <= 1'b0;
      s1Coll_q   <= 1'b0;
    end else begin
      s1Valid0_q <= respValid0;
      s1Valid1_q <= respValid1;
      s1Coll_q   <= coll;
      if (respValid0) s1Data0_q <= respData0;
      if (respValid1) s1Data1_q <= respData1;
    end
  end

  if (OUT_REG != 0) begin : g_outReg
    logic [DATA_W-1:0] s2Data0_q, s2Data1_q;
    logic              s2Valid0_q, s2Valid1_q, s2Coll_q;

    // Optional second stage: delays data, valid and collision flag together.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2Data0_q  <= '0;
        s2Data1_q  <= '0;
        s2Valid0_q <= 1'b0;
        s2Valid1_q <= 1'b0;
        s2Coll_q   <= 1'b0;
      end else begin
        s2Valid0_q <= s1Valid0_q;
        s2Valid1_q <= s1Valid1_q;
        s2Coll_q   <= s1Coll_q;
        if (s1Valid0_q) s2Data0_q <= s1Data0_q;
        if (s1Valid1_q) s2Data1_q <= s1Data1_q;
      end
    end

    assign out_0    = s2Data0_q;
    assign out_1    = s2Data1_q;
    assign valid_0  = s2Valid0_q;
    assign valid_1  = s2Valid1_q;
    assign coll_err = s2Coll_q;
  end else begin : g_noOutReg
    assign out_0    = s1Data0_q;
    assign out_1    = s1Data1_q;
    assign valid_0  = s1Valid0_q;
    assign valid_1  = s1Valid1_q;
    assign coll_err = s1Coll_q;
  end

endmodule

// File: tb/tb_true_dpr_param.sv
// tb_true_dpr_param: scoreboard bench for true_dpr_param.
// Instance A: defaults (8 bit, 4096 words, READ_FIRST, latency 1, clear on reset).
// Instance B: 32 bit / 4 lanes, 64 words, WRITE_FIRST, output register (latency 2).
// Instance C: 8 bit, 64 words, NO_CHANGE, no clear on reset.

module tb_true_dpr_param;

  typedef struct {
    logic [31:0] data;
    int          due;
  } sbEntry_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  sbEntry_t qA0[$], qA1[$], qB0[$], qC0[$];

  logic        enA0, wrA0, enA1, wrA1, validA0, validA1, busyA, collA;
  logic [0:0]  beA0, beA1;
  logic [11:0] addrA0, addrA1;
  logic [7:0]  inA0, inA1, outA0, outA1;

  logic        enB0, wrB0, enB1, wrB1, validB0, validB1, busyB, collB;
  logic [3:0]  beB0, beB1;
  logic [5:0]  addrB0, addrB1;
  logic [31:0] inB0, inB1, outB0, outB1;

  logic        enC0, wrC0, enC1, wrC1, validC0, validC1, busyC, collC;
  logic [0:0]  beC0, beC1;
  logic [5:0]  addrC0, addrC1;
  logic [7:0]  inC0, inC1, outC0, outC1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  true_dpr_param #(.DATA_W(8), .LANE_W(8), .ADDR_W(12), .RD_MODE(0), .OUT_REG(0), .INIT_CLEAR(1)) dutA (
    .clk(clk), .rst_n(rst_n), .init_busy(busyA),
    .en_0(enA0), .wr_en_0(wrA0), .be_0(beA0), .addr_0(addrA0), .in_0(inA0), .out_0(outA0), .valid_0(validA0),
    .en_1(enA1), .wr_en_1(wrA1), .be_1(beA1), .addr_1(addrA1), .in_1(inA1), .out_1(outA1), .valid_1(validA1),
    .coll_err(collA));

  true_dpr_param #(.DATA_W(32), .LANE_W(8), .ADDR_W(6), .RD_MODE(1), .OUT_REG(1), .INIT_CLEAR(1)) dutB (
    .clk(clk), .rst_n(rst_n), .init_busy(busyB),
    .en_0(enB0), .wr_en_0(wrB0), .be_0(beB0), .addr_0(addrB0), .in_0(inB0), .out_0(outB0), .valid_0(validB0),
    .en_1(enB1), .wr_en_1(wrB1), .be_1(beB1), .addr_1(addrB1), .in_1(inB1), .out_1(outB1), .valid_1(validB1),
    .coll_err(collB));

  true_dpr_param #(.DATA_W(8), .LANE_W(8), .ADDR_W(6), .RD_MODE(2), .OUT_REG(0), .INIT_CLEAR(0)) dutC (
    .clk(clk), .rst_n(rst_n), .init_busy(busyC),
    .en_0(enC0), .wr_en_0(wrC0), .be_0(beC0), .addr_0(addrC0), .in_0(inC0), .out_0(outC0), .valid_0(validC0),
    .en_1(enC1), .wr_en_1(wrC1), .be_1(beC1), .addr_1(addrC1), .in_1(inC1), .out_1(outC1), .valid_1(validC1),
    .coll_err(collC));

  // Scoreboard monitors: every valid pulse must match the oldest expectation, value and cycle.
  always @(negedge clk) begin : monA0
    sbEntry_t e;
    if (validA0 === 1'b1) begin
      total++;
      if (qA0.size() == 0) begin
        bad++;
        $display("[TB] FAIL A0_unexpected_valid got out=%h want no valid", outA0);
      end else begin
        e = qA0.pop_front();
        if (outA0 !== e.data[7:0] || cyc != e.due) begin
          bad++;
          $display("[TB] FAIL A0_read got %h@%0d want %h@%0d", outA0, cyc, e.data[7:0], e.due);
        end
      end
    end
  end

  always @(negedge clk) begin : monA1
    sbEntry_t e;
    if (validA1 === 1'b1) begin
      total++;
      if (qA1.size() == 0) begin
        bad++;
        $display("[TB] FAIL A1_unexpected_valid got out=%h want no valid", outA1);
      end else begin
        e = qA1.pop_front();
        if (outA1 !== e.data[7:0] || cyc != e.due) begin
          bad++;
          $display("[TB] FAIL A1_read got %h@%0d want %h@%0d", outA1, cyc, e.data[7:0], e.due);
        end
      end
    end
  end

  always @(negedge clk) begin : monB0
    sbEntry_t e;
    if (validB0 === 1'b1) begin
      total++;
      if (qB0.size() == 0) begin
        bad++;
        $display("[TB] FAIL B0_unexpected_valid got out=%h want no valid", outB0);
      end else begin
        e = qB0.pop_front();
        if (outB0 !== e.data || cyc != e.due) begin
          bad++;
          $display("[TB] FAIL B0_read got %h@%0d want %h@%0d", outB0, cyc, e.data, e.due);
        end
      end
    end
  end

  always @(negedge clk) begin : monC0
    sbEntry_t e;
    if (validC0 === 1'b1) begin
      total++;
      if (qC0.size() == 0) begin
        bad++;
        $display("[TB] FAIL C0_unexpected_valid got out=%h want no valid", outC0);
      end else begin
        e = qC0.pop_front();
        if (outC0 !== e.data[7:0] || cyc != e.due) begin
          bad++;
          $display("[TB] FAIL C0_read got %h@%0d want %h@%0d", outC0, cyc, e.data[7:0], e.due);
        end
      end
    end
  end

  // Drop every request on all instances.
  task automatic idleAll();
    enA0 = 0; wrA0 = 0; beA0 = 0; addrA0 = 0; inA0 = 0;
    enA1 = 0; wrA1 = 0; beA1 = 0; addrA1 = 0; inA1 = 0;
    enB0 = 0; wrB0 = 0; beB0 = 0; addrB0 = 0; inB0 = 0;
    enB1 = 0; wrB1 = 0; beB1 = 0; addrB1 = 0; inB1 = 0;
    enC0 = 0; wrC0 = 0; beC0 = 0; addrC0 = 0; inC0 = 0;
    enC1 = 0; wrC1 = 0; beC1 = 0; addrC1 = 0; inC1 = 0;
  endtask

  task automatic test_reset();
    int busyCnt;
    idleAll();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({outA0, validA0, collA, busyA} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset_state_A got out=%h v=%b c=%b busy=%b want 00 0 0 1", outA0, validA0, collA, busyA);
    end
    total++;
    if (busyC !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_busy_noclear got %b want 0", busyC);
    end
    // Requests held during the clear must be ignored.
    enA0 = 1; wrA0 = 0; addrA0 = 12'h005;
    enA1 = 1; wrA1 = 1; beA1 = 1; addrA1 = 12'h007; inA1 = 8'hFF;
    @(posedge clk);
    #1 rst_n = 1'b1;
    busyCnt = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (busyA === 1'b1) busyCnt++;
      else break;
    end
    total++;
    if (busyCnt != 4096) begin
      bad++;
      $display("[TB] FAIL clear_length got %0d want 4096", busyCnt);
    end
    idleAll();
    enA0 = 1; addrA0 = 12'hFFF; qA0.push_back('{data: 32'h0, due: cyc + 1});
    enA1 = 1; addrA1 = 12'h007; qA1.push_back('{data: 32'h0, due: cyc + 1});
    @(negedge clk);
    idleAll();
    repeat (4) @(negedge clk);
    total++;
    if (busyB !== 1'b0 || collA !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_clear_flags got busyB=%b coll=%b want 0 0", busyB, collA);
    end
    total++;
    if (qA0.size() + qA1.size() + qB0.size() + qC0.size() != 0) begin
      bad++;
      $display("[TB] FAIL reset_missing_valid got %0d pending want 0", qA0.size() + qA1.size() + qB0.size() + qC0.size());
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    enA0 = 1; wrA0 = 1; beA0 = 1; addrA0 = 12'h001; inA0 = 8'hAA; qA0.push_back('{data: 32'h0, due: cyc + 1});
    enA1 = 1; wrA1 = 1; beA1 = 1; addrA1 = 12'h002; inA1 = 8'hBB; qA1.push_back('{data: 32'h0, due: cyc + 1});
    enB0 = 1; wrB0 = 1; beB0 = 4'hF; addrB0 = 6'h01; inB0 = 32'h000000AA;
    qB0.push_back('{data: 32'h000000AA, due: cyc + 2});
    @(negedge clk);
    wrA0 = 0; qA0.push_back('{data: 32'hAA, due: cyc + 1});
    wrA1 = 0; qA1.push_back('{data: 32'hBB, due: cyc + 1});
    wrB0 = 0; qB0.push_back('{data: 32'h000000AA, due: cyc + 2});
    @(negedge clk);
    total++;
    if (collA !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_no_coll got %b want 0", collA);
    end
    idleAll();
    repeat (4) @(negedge clk);
    total++;
    if (qA0.size() + qA1.size() + qB0.size() != 0) begin
      bad++;
      $display("[TB] FAIL basic_missing_valid got %0d pending want 0", qA0.size() + qA1.size() + qB0.size());
    end
  endtask

  task automatic test_lanes();
    @(negedge clk);
    enB0 = 1; wrB0 = 1; beB0 = 4'hF; addrB0 = 6'h10; inB0 = 32'h11223344;
    qB0.push_back('{data: 32'h11223344, due: cyc + 2});
    @(negedge clk);
    beB0 = 4'b0101; inB0 = 32'hAABBCCDD;
    qB0.push_back('{data: 32'h11BB33DD, due: cyc + 2});
    @(negedge clk);
    beB0 = 4'b0000; inB0 = 32'hFFFFFFFF;
    qB0.push_back('{data: 32'h11BB33DD, due: cyc + 2});
    @(negedge clk);
    wrB0 = 0; qB0.push_back('{data: 32'h11BB33DD, due: cyc + 2});
    @(negedge clk);
    idleAll();
    repeat (4) @(negedge clk);
    total++;
    if (qB0.size() != 0) begin
      bad++;
      $display("[TB] FAIL lanes_missing_valid got %0d pending want 0", qB0.size());
    end
  endtask

  task automatic test_rd_mode();
    @(negedge clk);
    enA0 = 1; wrA0 = 1; beA0 = 1; addrA0 = 12'h005; inA0 = 8'h55; qA0.push_back('{data: 32'h00, due: cyc + 1});
    enB0 = 1; wrB0 = 1; beB0 = 4'hF; addrB0 = 6'h05; inB0 = 32'h55; qB0.push_back('{data: 32'h55, due: cyc + 2});
    enC0 = 1; wrC0 = 1; beC0 = 1; addrC0 = 6'h05; inC0 = 8'h55;
    @(negedge clk);
    inA0 = 8'h77; qA0.push_back('{data: 32'h55, due: cyc + 1});
    inB0 = 32'h77; qB0.push_back('{data: 32'h77, due: cyc + 2});
    wrC0 = 0; qC0.push_back('{data: 32'h55, due: cyc + 1});
    @(negedge clk);
    wrA0 = 0; qA0.push_back('{data: 32'h77, due: cyc + 1});
    wrB0 = 0; qB0.push_back('{data: 32'h77, due: cyc + 2});
    wrC0 = 1; inC0 = 8'h77;
    @(negedge clk);
    idleAll();
    @(negedge clk);
    total++;
    if (validC0 !== 1'b0 || outC0 !== 8'h55) begin
      bad++;
      $display("[TB] FAIL no_change_hold got v=%b out=%h want v=0 out=55", validC0, outC0);
    end
    enC0 = 1; wrC0 = 0; addrC0 = 6'h05; qC0.push_back('{data: 32'h77, due: cyc + 1});
    @(negedge clk);
    idleAll();
    repeat (4) @(negedge clk);
    total++;
    if (qA0.size() + qB0.size() + qC0.size() != 0) begin
      bad++;
      $display("[TB] FAIL rd_mode_missing_valid got %0d pending want 0", qA0.size() + qB0.size() + qC0.size());
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    enA0 = 1; wrA0 = 1; beA0 = 1; addrA0 = 12'h020; inA0 = 8'h12; qA0.push_back('{data: 32'h0, due: cyc + 1});
    enA1 = 1; wrA1 = 1; beA1 = 1; addrA1 = 12'h020; inA1 = 8'h34; qA1.push_back('{data: 32'h0, due: cyc + 1});
    @(negedge clk);
    total++;
    if (collA !== 1'b1) begin
      bad++;
      $display("[TB] FAIL coll_ww got %b want 1", collA);
    end
    wrA0 = 0; qA0.push_back('{data: 32'h12, due: cyc + 1});
    enA1 = 0; wrA1 = 0;
    @(negedge clk);
    total++;
    if (collA !== 1'b0) begin
      bad++;
      $display("[TB] FAIL coll_pulse_width got %b want 0", collA);
    end
    qA0.push_back('{data: 32'h12, due: cyc + 1});
    enA1 = 1; wrA1 = 1; inA1 = 8'h56; qA1.push_back('{data: 32'h12, due: cyc + 1});
    @(negedge clk);
    total++;
    if (collA !== 1'b1) begin
      bad++;
      $display("[TB] FAIL coll_rw got %b want 1", collA);
    end
    qA0.push_back('{data: 32'h56, due: cyc + 1});
    wrA1 = 0; qA1.push_back('{data: 32'h56, due: cyc + 1});
    @(negedge clk);
    total++;
    if (collA !== 1'b0) begin
      bad++;
      $display("[TB] FAIL coll_rr got %b want 0", collA);
    end
    idleAll();
    // Partial-lane write/write collision on the wide instance.
    enB0 = 1; wrB0 = 1; beB0 = 4'b0011; addrB0 = 6'h30; inB0 = 32'hAAAAAAAA;
    enB1 = 1; wrB1 = 1; beB1 = 4'b0110; addrB1 = 6'h30; inB1 = 32'hBBBBBBBB;
    qB0.push_back('{data: 32'h00BBAAAA, due: cyc + 2});
    @(negedge clk);
    enB1 = 0; wrB1 = 0; beB1 = 0;
    wrB0 = 0; qB0.push_back('{data: 32'h00BBAAAA, due: cyc + 2});
    @(negedge clk);
    idleAll();
    total++;
    if (collB !== 1'b1) begin
      bad++;
      $display("[TB] FAIL coll_lanes got %b want 1", collB);
    end
    @(negedge clk);
    total++;
    if (collB !== 1'b0) begin
      bad++;
      $display("[TB] FAIL coll_lanes_width got %b want 0", collB);
    end
    repeat (4) @(negedge clk);
    total++;
    if (qA0.size() + qA1.size() + qB0.size() != 0) begin
      bad++;
      $display("[TB] FAIL coll_missing_valid got %0d pending want 0", qA0.size() + qA1.size() + qB0.size());
    end
  endtask

  task automatic test_reset_mid_clear();
    int busyCnt;
    @(negedge clk);
    enA0 = 1; wrA0 = 1; beA0 = 1; addrA0 = 12'hF00; inA0 = 8'h5A; qA0.push_back('{data: 32'h0, due: cyc + 1});
    @(negedge clk);
    wrA0 = 0; qA0.push_back('{data: 32'h5A, due: cyc + 1});
    @(negedge clk);
    idleAll();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({outA0, validA0, collA, busyA, outB0} !== {8'h00, 1'b0, 1'b0, 1'b1, 32'h0}) begin
      bad++;
      $display("[TB] FAIL async_reset got outA=%h v=%b c=%b busy=%b outB=%h want 00 0 0 1 00000000",
               outA0, validA0, collA, busyA, outB0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    total++;
    if (busyA !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_clear_busy got %b want 1", busyA);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    busyCnt = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (busyA === 1'b1) busyCnt++;
      else break;
    end
    total++;
    if (busyCnt != 4096) begin
      bad++;
      $display("[TB] FAIL restart_clear_length got %0d want 4096", busyCnt);
    end
    enA0 = 1; wrA0 = 0; addrA0 = 12'hF00; qA0.push_back('{data: 32'h0, due: cyc + 1});
    @(negedge clk);
    idleAll();
    repeat (4) @(negedge clk);
    total++;
    if (qA0.size() != 0) begin
      bad++;
      $display("[TB] FAIL restart_missing_valid got %0d pending want 0", qA0.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lanes();
    test_rd_mode();
    test_collision();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
